// File: rtl/cnn_seq_pkg.sv
// rtl/cnn_seq_pkg.sv - shared types and constants for the CNN layer sequencer
package cnn_seq_pkg;

  localparam int TI     = 16;
  localparam int TO     = 16;
  localparam int N_PACK = 16;

  // Per-layer address strides: a 3x3 layer consumes Ti*To*9 weights packed N per word.
  localparam int W_INC3 = TI * TO * 9 / N_PACK;
  localparam int W_INC1 = TO;
  localparam int P_INC  = TO;

  localparam int CFG_FIRST   = 0;
  localparam int CFG_LAST_LO = 1;
  localparam int CFG_CONV    = 2;
  localparam int CFG_LAST_HI = 3;
  localparam int CFG_LIDX_LO = 4;
  localparam int CFG_BIAS_LO = 8;
  localparam int CFG_ACT_LO  = 13;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } seq_state_e;

  typedef struct packed {
    logic       is_conv3x3;
    logic [4:0] bias_shift;
    logic [2:0] act_shift;
  } layer_desc_t;

endpackage

// File: rtl/cnn_seq_desc_ram.sv
// rtl/cnn_seq_desc_ram.sv - layer descriptor table, one write port and one async read port
module cnn_seq_desc_ram
  import cnn_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  layer_desc_t   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output layer_desc_t   rdata_o
);

  layer_desc_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i && (32'(waddr_i) < 32'(DEPTH))) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = (32'(raddr_i) < 32'(DEPTH)) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/cnn_layer_sequencer.sv
// rtl/cnn_layer_sequencer.sv - runs the per-layer program/start/wait/advance loop for a whole network
// Optional per-layer done timeout enabled by defining CNN_SEQ_TIMEOUT_EN.
module cnn_layer_sequencer
  import cnn_seq_pkg::*;
#(
  parameter int N_LAYER_MAX = 16,
  parameter int W_LIDX      = 4,
  parameter int GAP_CYCLES  = 128
`ifdef CNN_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1 << 20
`endif
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              cfg_we,
  input  logic [W_LIDX-1:0] cfg_addr,
  input  logic [8:0]        cfg_wdata,
  input  logic [W_LIDX:0]   num_layers,
  input  logic [19:0]       base_weight_init,
  input  logic [11:0]       base_param_init,
  input  logic              seq_start,
  input  logic              seq_abort,
  input  logic              acc_layer_done,
  output logic [31:0]       acc_base_addr,
  output logic [31:0]       acc_layer_config,
  output logic              acc_layer_start,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              seq_err,
  output logic [W_LIDX-1:0] cur_layer
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  seq_state_e        state_q, state_d;
  logic [W_LIDX-1:0] idx_q, idx_d;
  logic [W_LIDX:0]   nl_q, nl_d;
  logic [19:0]       wbase_q, wbase_d;
  logic [11:0]       pbase_q, pbase_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       base_q, base_d;
  logic [31:0]       cfg_q, cfg_d;
  layer_desc_t       rd_desc;
  logic              last_layer;

`ifdef CNN_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  cnn_seq_desc_ram #(
    .DEPTH (N_LAYER_MAX),
    .AW    (W_LIDX)
  ) u_desc_ram (
    .clk_i   (HCLK),
    .we_i    (cfg_we && (state_q == S_IDLE)),
    .waddr_i (cfg_addr),
    .wdata_i (cfg_wdata),
    .raddr_i (idx_q),
    .rdata_o (rd_desc)
  );

  assign last_layer = ({1'b0, idx_q} == (nl_q - 1'b1));

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    nl_d            = nl_q;
    wbase_d         = wbase_q;
    pbase_d         = pbase_q;
    gap_d           = gap_q;
    done_d          = done_q;
    err_d           = err_q;
    base_d          = base_q;
    cfg_d           = cfg_q;
    acc_layer_start = 1'b0;
`ifdef CNN_SEQ_TIMEOUT_EN
    tmo_d           = tmo_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (seq_start) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          nl_d    = num_layers;
          wbase_d = base_weight_init;
          pbase_d = base_param_init;
          idx_d   = '0;
          if (32'(num_layers) > 32'(N_LAYER_MAX)) begin
            err_d = 1'b1;
          end else if (num_layers == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        base_d                      = {pbase_q, wbase_q};
        cfg_d                       = '0;
        cfg_d[CFG_ACT_LO +: 3]      = rd_desc.act_shift;
        cfg_d[CFG_BIAS_LO +: 5]     = rd_desc.bias_shift;
        cfg_d[CFG_LIDX_LO +: 4]     = 4'(idx_q);
        cfg_d[CFG_LAST_HI]          = last_layer;
        cfg_d[CFG_CONV]             = rd_desc.is_conv3x3;
        cfg_d[CFG_LAST_LO]          = last_layer;
        cfg_d[CFG_FIRST]            = (idx_q == '0);
        state_d                     = S_START;
      end
      S_START: begin
        acc_layer_start = 1'b1;
        state_d         = S_WAIT;
`ifdef CNN_SEQ_TIMEOUT_EN
        tmo_d           = '0;
`endif
      end
      S_WAIT: begin
        if (acc_layer_done) begin
          state_d = S_GAP;
          gap_d   = '0;
        end
`ifdef CNN_SEQ_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      S_GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          wbase_d = wbase_q + (rd_desc.is_conv3x3 ? 20'(W_INC3) : 20'(W_INC1));
          pbase_d = pbase_q + 12'(P_INC);
          idx_d   = idx_q + 1'b1;
          state_d = last_layer ? S_DONE : S_LOAD;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything, including a done arriving in the same cycle.
    if (seq_abort && (state_q != S_IDLE)) begin
      state_d         = S_IDLE;
      acc_layer_start = 1'b0;
      err_d           = 1'b1;
      done_d          = done_q;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      nl_q    <= '0;
      wbase_q <= '0;
      pbase_q <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      base_q  <= '0;
      cfg_q   <= '0;
`ifdef CNN_SEQ_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nl_q    <= nl_d;
      wbase_q <= wbase_d;
      pbase_q <= pbase_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
      err_q   <= err_d;
      base_q  <= base_d;
      cfg_q   <= cfg_d;
`ifdef CNN_SEQ_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign acc_base_addr    = base_q;
  assign acc_layer_config = cfg_q;
  assign seq_busy         = (state_q != S_IDLE);
  assign seq_done         = done_q;
  assign seq_err          = err_q;
  assign cur_layer        = idx_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb/tb_cnn_layer_sequencer.sv - randomized self-checking bench against a per-network reference model
module tb_cnn_layer_sequencer;

  localparam int GAP = 128;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [8:0]  cfg_wdata;
  logic [4:0]  num_layers;
  logic [19:0] base_weight_init;
  logic [11:0] base_param_init;
  logic        seq_start;
  logic        seq_abort;
  logic        acc_layer_done;
  logic [31:0] acc_base_addr;
  logic [31:0] acc_layer_config;
  logic        acc_layer_start;
  logic        seq_busy;
  logic        seq_done;
  logic        seq_err;
  logic [3:0]  cur_layer;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] tab [16];

  cnn_layer_sequencer #(
    .N_LAYER_MAX (16),
    .W_LIDX      (4),
    .GAP_CYCLES  (GAP)
  ) dut (
    .HCLK             (HCLK),
    .HRESET           (HRESET),
    .cfg_we           (cfg_we),
    .cfg_addr         (cfg_addr),
    .cfg_wdata        (cfg_wdata),
    .num_layers       (num_layers),
    .base_weight_init (base_weight_init),
    .base_param_init  (base_param_init),
    .seq_start        (seq_start),
    .seq_abort        (seq_abort),
    .acc_layer_done   (acc_layer_done),
    .acc_base_addr    (acc_base_addr),
    .acc_layer_config (acc_layer_config),
    .acc_layer_start  (acc_layer_start),
    .seq_busy         (seq_busy),
    .seq_done         (seq_done),
    .seq_err          (seq_err),
    .cur_layer        (cur_layer)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge HCLK);
  endtask

  task automatic write_desc(input int a, input logic [8:0] d);
    cfg_we = 1'b1; cfg_addr = 4'(a); cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
    tab[a] = d;
  endtask

  // One network run; the model derives every layer's addresses/config and event times.
  task automatic run_net(input int nl, input int wi, input int pi, input int lat_fix,
                         input bit hold_mode, input int abort_layer, input bit poke);
    logic [31:0] eb [16];
    logic [31:0] ec [16];
    logic [8:0]  d;
    int w, p, cyc, starts, done_at, exp_next, hold_from, lat, budget, abort_cyc, watch_end, start_cyc;
    bit hold_kill, finished, aborted;
    w = wi; p = pi;
    for (int k = 0; k < nl; k++) begin
      d = tab[k];
      eb[k] = (32'(p) << 20) | 32'(w);
      ec[k] = (32'(d[2:0]) << 13) | (32'(d[7:3]) << 8) | (32'(k) << 4) |
              ((k == nl - 1) ? 32'hA : 32'h0) | (32'(d[8]) << 2) | ((k == 0) ? 32'h1 : 32'h0);
      w = (w + (d[8] ? 144 : 16)) % (1 << 20);
      p = (p + 16) % 4096;
    end
    starts = 0; done_at = -1; exp_next = 2; hold_from = -1; hold_kill = 0;
    finished = 0; aborted = 0; abort_cyc = -1; watch_end = -1; start_cyc = -1;
    budget = 100 + nl * (GAP + 80);
    num_layers = 5'(nl); base_weight_init = 20'(wi); base_param_init = 12'(pi);
    seq_start = 1'b1;
    tick();
    seq_start = 1'b0;
    cyc = 1;
    if (nl > 0) check("busy_after_start", 32'(seq_busy), 1);
    while (!finished && cyc < budget) begin
      if (acc_layer_start) begin
        if (aborted || starts >= nl) begin
          check("extra_start", 1, 0);
        end else begin
          check($sformatf("start%0d_time", starts), cyc, exp_next);
          check($sformatf("base%0d", starts), acc_base_addr, eb[starts]);
          check($sformatf("cfg%0d", starts), acc_layer_config, ec[starts]);
          check($sformatf("cur_layer%0d", starts), 32'(cur_layer), starts);
          lat = (lat_fix > 0) ? lat_fix : $urandom_range(4, 60);
          done_at = cyc + lat;
          start_cyc = cyc;
          if (hold_from >= 0 && cyc >= hold_from) hold_kill = 1;
          starts++;
        end
      end
      if (seq_done) begin
        if (aborted) begin
          check("done_after_abort", 32'(seq_done), 0);
        end else begin
          check("seq_done_time", cyc, exp_next);
          check("start_count", starts, nl);
          check("err_clean", 32'(seq_err), 0);
          finished = 1;
        end
      end
      if (aborted && cyc == abort_cyc + 1) begin
        check("abort_busy", 32'(seq_busy), 0);
        check("abort_err", 32'(seq_err), 1);
        check("abort_done", 32'(seq_done), 0);
      end
      if (aborted && cyc >= watch_end) finished = 1;
      seq_start = 1'b0; cfg_we = 1'b0; seq_abort = 1'b0;
      acc_layer_done = (cyc == done_at) || (hold_from >= 0 && cyc >= hold_from);
      if (cyc == done_at) begin
        exp_next = cyc + GAP + 2;
        if (hold_mode && starts < nl) hold_from = cyc + GAP;
      end
      if (hold_kill) begin
        hold_from = -1;
        hold_kill = 0;
      end
      if (!aborted && abort_layer >= 0 && starts == abort_layer + 1 && cyc == start_cyc + 3) begin
        seq_abort = 1'b1; aborted = 1; abort_cyc = cyc; done_at = -1; hold_from = -1;
        watch_end = cyc + GAP + 40;
      end
      if (poke && cyc == 5) begin
        seq_start = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = ~tab[0];
      end
      tick();
      cyc++;
    end
    if (!finished) check("run_timeout", 0, 1);
    seq_start = 1'b0; cfg_we = 1'b0; seq_abort = 1'b0; acc_layer_done = 1'b0;
    check("busy_idle_end", 32'(seq_busy), 0);
  endtask

  initial begin
    int sc;
    HRESET = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; num_layers = '0;
    base_weight_init = '0; base_param_init = '0; seq_start = 1'b0; seq_abort = 1'b0;
    acc_layer_done = 1'b0;
    for (int i = 0; i < 16; i++) tab[i] = '0;
    repeat (3) tick();
    HRESET = 1'b0;
    tick();
    check("rst_base", acc_base_addr, 0);
    check("rst_cfg", acc_layer_config, 0);
    check("rst_start", 32'(acc_layer_start), 0);
    check("rst_busy", 32'(seq_busy), 0);
    check("rst_done", 32'(seq_done), 0);
    check("rst_err", 32'(seq_err), 0);
    check("rst_cur", 32'(cur_layer), 0);

    write_desc(0, {1'b0, 5'd9, 3'd7});
    write_desc(1, {1'b1, 5'd17, 3'd7});
    write_desc(2, {1'b1, 5'd17, 3'd7});
    run_net(3, 0, 0, 50, 0, -1, 0);

    run_net(0, 0, 0, 0, 0, -1, 0);

    num_layers = 5'd17; seq_start = 1'b1;
    tick();
    seq_start = 1'b0;
    sc = 0;
    for (int i = 0; i < 20; i++) begin
      if (acc_layer_start || seq_busy) sc++;
      tick();
    end
    check("bad_nl_activity", sc, 0);
    check("bad_nl_err", 32'(seq_err), 1);
    check("bad_nl_done", 32'(seq_done), 0);

    run_net(3, 0, 0, 0, 0, 1, 0);
    run_net(3, 0, 0, 0, 0, -1, 0);

    write_desc(3, 9'($urandom_range(0, 511)));
    run_net(4, 32'($urandom_range(0, (1 << 20) - 1)), 32'($urandom_range(0, 4095)), 0, 1, -1, 1);
    run_net(2, 5, 7, 0, 0, -1, 0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) write_desc(i, 9'($urandom_range(0, 511)));
      run_net($urandom_range(1, 16), 32'($urandom_range((1 << 20) - 3000, (1 << 20) - 1)),
              32'($urandom_range(3800, 4095)), 0, (r % 2), -1, 0);
    end

    num_layers = 5'd3; seq_start = 1'b1;
    tick();
    seq_start = 1'b0;
    repeat (10) tick();
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    check("midrst_busy", 32'(seq_busy), 0);
    check("midrst_base", acc_base_addr, 0);
    check("midrst_cfg", acc_layer_config, 0);
    check("midrst_cur", 32'(cur_layer), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
